// File: rtl/or_approx_pkg.sv
// Shared types and constants for the sequential
// approximate 8x8 multiplier built from or_4x4.
package or_approx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W   = 4;
  localparam int N_STEPS = 4;

  // left shift applied to each sub-product: {0,4,4,8}
  function automatic logic [3:0] step_shift(
    input logic [1:0] s
  );
    logic [3:0] r;
    unique case (s)
      2'd0:    r = 4'd0;
      2'd1:    r = 4'd4;
      2'd2:    r = 4'd4;
      default: r = 4'd8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/or_approx_8x8_seq_or_4x4.sv
// Approximate 4x4 multiplier: partial-product
// columns are ORed and product bit 7 is forced high.
module or_4x4
  import or_approx_pkg::*;
(
  input  logic [NIB_W-1:0]   x,
  input  logic [NIB_W-1:0]   y,
  output logic [2*NIB_W-1:0] p
);

  // OR the shifted partial-product rows together
  always_comb begin
    p = '0;
    for (int i = 0; i < NIB_W; i++) begin
      if (y[i]) begin
        p = p | ({{NIB_W{1'b0}}, x} << i);
      end
    end
    p[2*NIB_W-1] = 1'b1;
  end

endmodule

// File: rtl/or_approx_8x8_seq.sv
// Sequential approximate 8x8 multiplier: four
// or_4x4 sub-products, one per cycle, accumulated.
module or_approx_8x8_seq
  import or_approx_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p,
  output logic             ovf,
  output logic             busy
);

  localparam int SUM_W = OUT_W + 1;

  state_t             state;
  logic [1:0]         step;
  logic [7:0]         a_q;
  logic [7:0]         b_q;
  logic [OUT_W-1:0]   acc;
  logic               ovf_q;

  logic [NIB_W-1:0]   nib_x;
  logic [NIB_W-1:0]   nib_y;
  logic [2*NIB_W-1:0] sub_p;
  logic [SUM_W-1:0]   addend;
  logic [SUM_W-1:0]   sum;
  logic               accept;

  assign in_ready  = (state == IDLE) ||
                     ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign p         = acc;
  assign ovf       = ovf_q;
  assign accept    = in_valid && in_ready;

  // pick the nibble pair for the current step
  always_comb begin
    nib_x = a_q[3:0];
    nib_y = b_q[3:0];
    unique case (step)
      2'd0: begin
        nib_x = a_q[3:0];
        nib_y = b_q[3:0];
      end
      2'd1: begin
        nib_x = a_q[7:4];
        nib_y = b_q[3:0];
      end
      2'd2: begin
        nib_x = a_q[3:0];
        nib_y = b_q[7:4];
      end
      default: begin
        nib_x = a_q[7:4];
        nib_y = b_q[7:4];
      end
    endcase
  end

  or_4x4 u_or_4x4 (
    .x (nib_x),
    .y (nib_y),
    .p (sub_p)
  );

  // exact add, one bit wider so the carry is visible
  always_comb begin
    addend = SUM_W'(sub_p) << step_shift(step);
    sum    = {1'b0, acc} + addend;
  end

  // control FSM with accumulator and sticky carry
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= 2'd0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      acc   <= '0;
      ovf_q <= 1'b0;
      step  <= 2'd0;
      state <= CALC;
    end else begin
      unique case (state)
        CALC: begin
          acc   <= sum[OUT_W-1:0];
          ovf_q <= ovf_q | sum[OUT_W];
          step  <= step + 2'd1;
          if (step == 2'(N_STEPS - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/or_approx_8x8_seq.md
# or_approx_8x8_seq

Sequential 8x8 approximate recursive multiplier built from a single time-multiplexed `or_4x4` approximate multiplier. It sits directly downstream of that 4x4 stage:
- splits each 8-bit operand pair into four 4x4 sub-products;
- feeds them to the `or_4x4` instance one per cycle;
- shifts and exactly accumulates the 8-bit approximate results into the final product.

Valid/ready handshakes on both sides let it drop into a streaming datapath.

## Interface
- `OUT_W`, default 16: product width. Legal values are 16 and 17; 17 makes wrap-around impossible.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept operands this cycle.
- `a` input 8: multiplicand, unsigned.
- `b` input 8: multiplier, unsigned.
- `out_valid` output 1: `p` and `ovf` valid.
- `out_ready` input 1: consumer accepts the result.
- `p` output OUT_W: approximate product, accumulated modulo 2^OUT_W.
- `ovf` output 1: accumulation carried out of bit OUT_W-1. Always 0 when OUT_W=17.
- `busy` output 1: high in CALC.

## Operation
- States: IDLE, CALC, DONE. A 2-bit `step` counter runs in CALC.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `a` and `b`, clear `acc` and `ovf`, set `step`=0, go to CALC.
- CALC: `in_ready`=0 and `busy`=1. Each cycle, the `or_4x4` inputs are selected by `step`, and the 8-bit result is added to `acc` with the shift shown:
  - step 0: `aL`,`bL`, shift 0.
  - step 1: `aH`,`bL`, shift 4.
  - step 2: `aL`,`bH`, shift 4.
  - step 3: `aH`,`bH`, shift 8.
  - `aL`/`aH` are the low/high nibbles of the latched `a`; `bL`/`bH` likewise for `b`.
- Accumulation rules:
  - Addition is exact binary addition of width OUT_W+1.
  - The low OUT_W bits are kept.
  - The carry bit is ORed into a sticky `ovf`.
  - After step 3, go to DONE.
- DONE:
  - `out_valid`=1; `p`=`acc`.
  - `in_ready`=`out_ready`.
  - `out_ready`=1 and `in_valid`=0: go to IDLE.
  - `out_ready`=1 and `in_valid`=1: the result is consumed and the new operands are accepted on the same edge; go to CALC.
  - `out_ready`=0: hold `p`, `ovf` and `out_valid` stable.
- Sub-product error model is inherited unchanged from `or_4x4`:
  - Columns are ORed, not added.
  - Product bit 7 is forced to 1, so a 0x0 sub-product yields 0x80.
- `a`/`b` are ignored whenever `in_ready`=0. Operands need not be held after acceptance.

## Timing
- Reset: next state IDLE. `in_ready`=1; `out_valid`=0, `busy`=0, `p`=0, `ovf`=0; `step`=0.
- Reset in CALC or DONE abandons the operation and drops the result.
- Latency: accept at edge N; `out_valid` is high after edge N+4, i.e. 4 CALC cycles.
- Throughput: one product every 5 cycles with `out_ready` tied high, using the DONE-to-CALC bypass.
- `in_ready` is combinational from state and `out_ready` only. It has no path from `in_valid`.
- `p` and `ovf` are registered. `or_4x4` sits combinationally between the operand mux and the adder within one cycle.

## Structure
- Shared package `or_approx_pkg`:
  - state enum `{IDLE, CALC, DONE}`;
  - `NIB_W`=4 and `N_STEPS`=4;
  - per-step shift amounts `{0,4,4,8}`.
- One sub-module: a single `or_4x4` instance, fed by a step-indexed nibble mux.
- No other hierarchy.

## Test plan
- Reset, then `a`=0x01, `b`=0x01, `out_ready`=1:
  - `out_valid` rises 4 cycles after accept;
  - `p`=0x9081, `ovf`=0.
- `a`=0x00, `b`=0x00: `p`=0x9080, `ovf`=0.
- `a`=0xFF, `b`=0xFF:
  - OUT_W=16: `p`=0x1FDF, `ovf`=1;
  - OUT_W=17: `p`=0x11FDF, `ovf`=0.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid`.
  - `p`, `out_valid` and `in_ready`=0 held stable;
  - a new `in_valid` is not accepted;
  - release → the result is consumed in one cycle.
- Back-to-back: `in_valid`=1 continuously, `out_ready`=1, operands (0x01,0x01) then (0x00,0x00):
  - results 0x9081 then 0x9080;
  - 5 cycles apart.
- `rst` asserted at step 2 of a CALC:
  - next cycle `out_valid`=0, `p`=0, `in_ready`=1;
  - a following (0x01,0x01) transaction still yields 0x9081.
